gcd_dual_mode_engine: RTL and testbench

- Parametrised next-generation GCD unit: computes gcd(x, y) of two WIDTH-bit unsigned operands.
- Two run-time algorithms: subtractive Euclid (mode=0) and binary/Stein (mode=1).
- Defined zero-operand handling, a busy indication, and a go/done handshake with the result held until the next start.
- Drop-in arithmetic block for datapaths that need a multi-cycle GCD with deterministic handshake.

---
 rtl/gcd_dual_mode_engine.sv | 130 +++++++++++++
 tb/tb_gcd_dual_mode_engine.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/gcd_dual_mode_engine.sv
// Multi-cycle GCD unit: subtractive Euclid (mode=0) or binary Stein (mode=1).
// Optional iteration counter output enabled by defining GCD_ITER_COUNT_EN.
module gcd_dual_mode_engine #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             mode,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
`ifdef GCD_ITER_COUNT_EN
    ,
    output logic [CNT_W-1:0] iter_cnt
`endif
);

    // Handshake: go is accepted on any edge where busy=0 (IDLE or DONE); it
    // latches x, y and mode. done/out then hold until the next accepted go.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int K_W = $clog2(WIDTH) + 1;
    localparam logic [K_W-1:0] K_ONE = 1;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [K_W-1:0]   k_q, k_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] out_q, out_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        mode_d  = mode_q;
        out_d   = out_q;
        case (state_q)
            IDLE, DONE: begin
                if (go) begin
                    a_d     = x;
                    b_d     = y;
                    k_d     = '0;
                    mode_d  = mode;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Reductions never produce zero, so a zero operand can only
                // be seen on the first step.
                if (a_q == '0 || b_q == '0) begin
                    out_d   = a_q | b_q;
                    state_d = DONE;
                end else if (a_q == b_q) begin
                    out_d   = mode_q ? (a_q << k_q) : a_q;
                    state_d = DONE;
                end else if (!mode_q) begin
                    if (a_q > b_q) a_d = a_q - b_q;
                    else           b_d = b_q - a_q;
                end else begin
                    if (!a_q[0] && !b_q[0]) begin
                        a_d = a_q >> 1;
                        b_d = b_q >> 1;
                        k_d = k_q + K_ONE;
                    end else if (!a_q[0]) begin
                        a_d = a_q >> 1;
                    end else if (!b_q[0]) begin
                        b_d = b_q >> 1;
                    end else if (a_q > b_q) begin
                        a_d = (a_q - b_q) >> 1;
                    end else begin
                        b_d = (b_q - a_q) >> 1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            mode_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
        end
    end

    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);
    assign out  = out_q;

`ifdef GCD_ITER_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == CALC) begin
            if (!(&cnt_q)) cnt_d = cnt_q + CNT_ONE;
        end else if (go) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign iter_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_gcd_dual_mode_engine.sv
// Directed and swept checks of gcd_dual_mode_engine at WIDTH=8 and WIDTH=16.
// Define GCD_ITER_COUNT_EN to also check the iteration counter.
module tb_gcd_dual_mode_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic go8, mode8;
  logic [7:0] x8, y8, out8;
  logic busy8, done8;
  logic go16, mode16;
  logic [15:0] x16, y16, out16;
  logic busy16, done16;
`ifdef GCD_ITER_COUNT_EN
  logic [15:0] iter_cnt8, iter_cnt16;
`endif

  gcd_dual_mode_engine #(.WIDTH(8), .CNT_W(16)) dut8 (
    .clk(clk), .rst(rst), .go(go8), .mode(mode8), .x(x8), .y(y8),
    .busy(busy8), .done(done8), .out(out8)
`ifdef GCD_ITER_COUNT_EN
    , .iter_cnt(iter_cnt8)
`endif
  );

  gcd_dual_mode_engine #(.WIDTH(16), .CNT_W(16)) dut16 (
    .clk(clk), .rst(rst), .go(go16), .mode(mode16), .x(x16), .y(y16),
    .busy(busy16), .done(done16), .out(out16)
`ifdef GCD_ITER_COUNT_EN
    , .iter_cnt(iter_cnt16)
`endif
  );

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int gcd_ref(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // busy and done must never be high together
  always @(negedge clk) begin
    if (!rst) begin
      check("busy_done_excl8", {31'b0, busy8 & done8}, 32'd0);
      check("busy_done_excl16", {31'b0, busy16 & done16}, 32'd0);
    end
  end

  // All driver tasks start and end just after a falling edge.
  task automatic start8(input logic m, input logic [7:0] a, input logic [7:0] b);
    go8 = 1'b1; mode8 = m; x8 = a; y8 = b;
    @(negedge clk);
    go8 = 1'b0; mode8 = ~m; x8 = 8'($urandom_range(255)); y8 = 8'($urandom_range(255));
    check("start_busy8", {31'b0, busy8}, 32'd1);
    check("start_done8", {31'b0, done8}, 32'd0);
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done8 && n < 500);
    check("timeout8", {31'b0, done8}, 32'd1);
  endtask

  task automatic run8(input string tag, input logic m, input logic [7:0] a, input logic [7:0] b,
                      input int exp_out, input int exp_lat);
    int n;
    start8(m, a, b);
    wait_done8(n);
    check({tag, "_out"}, {24'b0, out8}, exp_out);
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_busy"}, {31'b0, busy8}, 32'd0);
`ifdef GCD_ITER_COUNT_EN
    check({tag, "_iter"}, {16'b0, iter_cnt8}, exp_lat);
`endif
  endtask

  task automatic run16(input string tag, input logic m, input logic [15:0] a, input logic [15:0] b,
                       input int exp_out);
    int n;
    go16 = 1'b1; mode16 = m; x16 = a; y16 = b;
    @(negedge clk);
    go16 = 1'b0; x16 = '0; y16 = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done16 && n < 2000);
    check({tag, "_timeout"}, {31'b0, done16}, 32'd1);
    check({tag, "_out"}, {16'b0, out16}, exp_out);
    check({tag, "_ref"}, {16'b0, out16}, gcd_ref(int'(a), int'(b)));
  endtask

  initial begin
    int n;
    int idx;
    int cycles;
    logic prev_done;

    rst = 1'b1;
    go8 = 1'b0; mode8 = 1'b0; x8 = '0; y8 = '0;
    go16 = 1'b0; mode16 = 1'b0; x16 = '0; y16 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy8}, 32'd0);
    check("rst_done", {31'b0, done8}, 32'd0);
    check("rst_out", {24'b0, out8}, 32'd0);
`ifdef GCD_ITER_COUNT_EN
    check("rst_iter", {16'b0, iter_cnt8}, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    run8("euclid_12_18", 1'b0, 8'd12, 8'd18, 6, 3);
    run8("stein_48_18", 1'b1, 8'd48, 8'd18, 6, 6);
    run8("euclid_0_37", 1'b0, 8'd0, 8'd37, 37, 1);
    run8("stein_0_37", 1'b1, 8'd0, 8'd37, 37, 1);
    run8("euclid_0_0", 1'b0, 8'd0, 8'd0, 0, 1);
    run8("stein_0_0", 1'b1, 8'd0, 8'd0, 0, 1);
    run8("stein_37_0", 1'b1, 8'd37, 8'd0, 37, 1);

    run16("w16_stein", 1'b1, 16'd65535, 16'd255, 255);
    run16("w16_euclid", 1'b0, 16'd65535, 16'd255, 255);

    // go during CALC must be ignored
    start8(1'b0, 8'd12, 8'd18);
    go8 = 1'b1; mode8 = 1'b1; x8 = 8'd7; y8 = 8'd7;
    @(negedge clk);
    go8 = 1'b0;
    wait_done8(n);
    check("ignore_go_out", {24'b0, out8}, 32'd6);
    check("ignore_go_lat", n + 1, 32'd3);

    // done and out hold until the next go
    repeat (3) @(negedge clk);
    check("hold_done", {31'b0, done8}, 32'd1);
    check("hold_out", {24'b0, out8}, 32'd6);
    run8("after_done_9_6", 1'b0, 8'd9, 8'd6, 3, 3);

    // reset mid-operation
    start8(1'b1, 8'd48, 8'd18);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'b0, busy8}, 32'd0);
    check("midrst_done", {31'b0, done8}, 32'd0);
    check("midrst_out", {24'b0, out8}, 32'd0);
`ifdef GCD_ITER_COUNT_EN
    check("midrst_iter", {16'b0, iter_cnt8}, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // sweep with go pulsed
    for (int m = 0; m < 2; m++) begin
      for (int a = 1; a <= 15; a++) begin
        for (int b = 1; b <= 15; b++) begin
          start8(m[0], 8'(a), 8'(b));
          exp_q.push_back(gcd_ref(a, b));
          wait_done8(n);
          check("sweep_out", {24'b0, out8}, exp_q.pop_front());
        end
      end
    end

    // sweep with go held high: done pulses once per result
    for (int m = 0; m < 2; m++) begin
      go8 = 1'b1; mode8 = m[0]; x8 = 8'd1; y8 = 8'd1;
      exp_q.push_back(1);
      idx = 1;
      cycles = 0;
      prev_done = 1'b1;
      while (exp_q.size() > 0 && cycles < 20000) begin
        @(negedge clk);
        cycles++;
        if (prev_done) check("held_done_pulse", {31'b0, done8}, 32'd0);
        prev_done = done8;
        if (done8) begin
          check("held_out", {24'b0, out8}, exp_q.pop_front());
          if (idx < 225) begin
            x8 = 8'(idx / 15 + 1);
            y8 = 8'(idx % 15 + 1);
            exp_q.push_back(gcd_ref(idx / 15 + 1, idx % 15 + 1));
            idx++;
          end else begin
            go8 = 1'b0;
          end
        end
      end
      check("held_timeout", exp_q.size(), 32'd0);
      go8 = 1'b0;
      exp_q.delete();
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
